pipelined_mac_multiplier: RTL

PIPELINED_MAC_MULTIPLIER -- requirements
Module: pipelined_mac_multiplier

---
 rtl/pipelined_mac_multiplier.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/pipelined_mac_multiplier.sv
// Purpose: pipelined signed/unsigned A_W x B_W multiplier with an optional accumulate on each delivered product.
// Latency: LATENCY cycles from accept to out_valid when downstream never stalls.
// Backpressure: global stall; every stage holds while out_valid & ~out_ready, and in_ready drops.
module pipelined_mac_multiplier #(
    parameter int A_W     = 8,
    parameter int B_W     = 8,
    parameter int LATENCY = 3,
    parameter int ACC_W   = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [A_W-1:0]       a,
    input  logic [B_W-1:0]       b,
    input  logic                 is_signed,
    input  logic                 acc_en,
    input  logic                 acc_clr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [A_W+B_W-1:0]   product,
    output logic [ACC_W-1:0]     acc,
    output logic                 acc_ovf
);

    localparam int P_W = A_W + B_W;

    logic               advance;

    logic               s0_vld;
    logic               s0_sgn;
    logic               s0_en;
    logic               s0_clr;
    logic [A_W-1:0]     s0_a;
    logic [B_W-1:0]     s0_b;

    logic [LATENCY-1:1] vld;
    logic [LATENCY-1:1] sgn;
    logic [LATENCY-1:1] en;
    logic [LATENCY-1:1] clr;
    logic [P_W-1:0]     prod_q [1:LATENCY-1];

    logic [P_W-1:0]     a_ext;
    logic [P_W-1:0]     b_ext;
    logic [P_W-1:0]     mul_res;

    logic               xfer;
    logic               sgn_out;
    logic               en_out;
    logic               clr_out;
    logic [ACC_W-1:0]   acc_base;
    logic [ACC_W-1:0]   add_ext;
    logic [ACC_W:0]     sum;
    logic               add_ovf;

    assign out_valid = vld[LATENCY-1];
    assign product   = prod_q[LATENCY-1];
    assign advance   = out_ready | ~out_valid;
    assign in_ready  = advance;

    assign sgn_out   = sgn[LATENCY-1];
    assign en_out    = en[LATENCY-1];
    assign clr_out   = clr[LATENCY-1];
    assign xfer      = out_valid & out_ready;

    // Widening both operands to the full product width makes one modulo-2^P_W
    // multiply exact for both two's complement and unsigned beats.
    always_comb begin
        a_ext   = s0_sgn ? {{B_W{s0_a[A_W-1]}}, s0_a} : {{B_W{1'b0}}, s0_a};
        b_ext   = s0_sgn ? {{A_W{s0_b[B_W-1]}}, s0_b} : {{A_W{1'b0}}, s0_b};
        mul_res = a_ext * b_ext;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s0_vld <= 1'b0;
            s0_sgn <= 1'b0;
            s0_en  <= 1'b0;
            s0_clr <= 1'b0;
            s0_a   <= '0;
            s0_b   <= '0;
            vld    <= '0;
            sgn    <= '0;
            en     <= '0;
            clr    <= '0;
            for (int i = 1; i < LATENCY; i++) begin
                prod_q[i] <= '0;
            end
        end else if (advance) begin
            s0_vld    <= in_valid;
            s0_sgn    <= is_signed;
            s0_en     <= acc_en;
            s0_clr    <= acc_clr;
            s0_a      <= a;
            s0_b      <= b;
            vld[1]    <= s0_vld;
            sgn[1]    <= s0_sgn;
            en[1]     <= s0_en;
            clr[1]    <= s0_clr;
            prod_q[1] <= mul_res;
            for (int i = 2; i < LATENCY; i++) begin
                vld[i]    <= vld[i-1];
                sgn[i]    <= sgn[i-1];
                en[i]     <= en[i-1];
                clr[i]    <= clr[i-1];
                prod_q[i] <= prod_q[i-1];
            end
        end
    end

    // Overflow is judged against the post-clear base so a clearing beat starts fresh.
    always_comb begin
        acc_base            = clr_out ? '0 : acc;
        add_ext             = {ACC_W{sgn_out & product[P_W-1]}};
        add_ext[P_W-1:0]    = product;
        sum                 = {1'b0, acc_base} + {1'b0, add_ext};
        if (sgn_out) begin
            add_ovf = (acc_base[ACC_W-1] == add_ext[ACC_W-1]) &&
                      (sum[ACC_W-1] != acc_base[ACC_W-1]);
        end else begin
            add_ovf = sum[ACC_W];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc     <= '0;
            acc_ovf <= 1'b0;
        end else if (xfer) begin
            if (en_out) begin
                acc     <= sum[ACC_W-1:0];
                acc_ovf <= (acc_ovf & ~clr_out) | add_ovf;
            end else if (clr_out) begin
                acc     <= '0;
                acc_ovf <= 1'b0;
            end
        end
    end

endmodule
